// File: rtl/mnist_image_packer.sv
// Pixel-stream front end: binarizes raster-order pixels and packs one whole image
// into a single wide word, emitted with its label and last flag on a valid/ready beat.
module mnist_image_packer #(
   parameter int USER_WIDTH  = 8,
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_X       = 28,
   parameter int IMG_Y       = 28,
   parameter int THRESHOLD   = 127,
   localparam int INPUT_WIDTH = IMG_X * IMG_Y
) (
   input  logic                   reset_n,
   input  logic                   clk,
   input  logic                   cke,
   input  logic [USER_WIDTH-1:0]  s_user,
   input  logic                   s_last,
   input  logic [PIXEL_WIDTH-1:0] s_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic [USER_WIDTH-1:0]  m_user,
   output logic                   m_last,
   output logic [INPUT_WIDTH-1:0] m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [31:0]            image_count
);

   localparam int CNT_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
   localparam logic [CNT_W-1:0]       LAST_IDX = CNT_W'(INPUT_WIDTH - 1);
   localparam logic [PIXEL_WIDTH-1:0] THR      = PIXEL_WIDTH'(THRESHOLD);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [INPUT_WIDTH-1:0] asm_data_q, asm_data_d;
   logic [USER_WIDTH-1:0]  asm_user_q, asm_user_d;
   logic                   asm_last_q, asm_last_d;
   logic [INPUT_WIDTH-1:0] m_data_q, m_data_d;
   logic [USER_WIDTH-1:0]  m_user_q, m_user_d;
   logic                   m_last_q, m_last_d;
   logic                   m_valid_q, m_valid_d;
   logic [31:0]            count_q, count_d;

   logic at_final, accept, consume, pix_bit;

   always_comb begin
      at_final   = (cnt_q == LAST_IDX);
      // Only the final pixel waits for output space; earlier pixels always flow.
      s_ready    = cke & ~(at_final & m_valid_q & ~m_ready);
      accept     = s_valid & s_ready;
      consume    = cke & m_valid_q & m_ready;
      pix_bit    = (s_data > THR);

      cnt_d      = cnt_q;
      asm_data_d = asm_data_q;
      asm_user_d = asm_user_q;
      asm_last_d = asm_last_q;
      m_data_d   = m_data_q;
      m_user_d   = m_user_q;
      m_last_d   = m_last_q;
      m_valid_d  = m_valid_q;
      count_d    = count_q;

      if (accept) begin
         asm_data_d[cnt_q] = pix_bit;
         if (cnt_q == '0) begin
            asm_user_d = s_user;
            asm_last_d = s_last;
         end else begin
            asm_last_d = asm_last_q | s_last;
         end
         cnt_d = at_final ? '0 : cnt_q + 1'b1;
      end

      // Every bit of the assembly has been rewritten by this image before transfer.
      if (accept && at_final) begin
         m_data_d  = asm_data_d;
         m_user_d  = asm_user_d;
         m_last_d  = asm_last_d;
         m_valid_d = 1'b1;
         count_d   = count_q + 32'd1;
      end else if (consume) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         asm_data_q <= '0;
         asm_user_q <= '0;
         asm_last_q <= 1'b0;
         m_data_q   <= '0;
         m_user_q   <= '0;
         m_last_q   <= 1'b0;
         m_valid_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         cnt_q      <= cnt_d;
         asm_data_q <= asm_data_d;
         asm_user_q <= asm_user_d;
         asm_last_q <= asm_last_d;
         m_data_q   <= m_data_d;
         m_user_q   <= m_user_d;
         m_last_q   <= m_last_d;
         m_valid_q  <= m_valid_d;
         count_q    <= count_d;
      end
   end

   assign m_data      = m_data_q;
   assign m_user      = m_user_q;
   assign m_last      = m_last_q;
   assign m_valid     = m_valid_q;
   assign image_count = count_q;

endmodule

// File: tb/tb_mnist_image_packer.sv
// Self-checking bench for mnist_image_packer: scoreboard of expected images,
// popped and compared whenever the DUT hands off an output word.
module tb_mnist_image_packer;

   localparam int NPIX = 784;

   logic             reset_n, clk, cke;
   logic [7:0]       s_user;
   logic             s_last;
   logic [7:0]       s_data;
   logic             s_valid, s_ready;
   logic [7:0]       m_user;
   logic             m_last;
   logic [NPIX-1:0]  m_data;
   logic             m_valid, m_ready;
   logic [31:0]      image_count;

   mnist_image_packer dut (
      .reset_n(reset_n), .clk(clk), .cke(cke),
      .s_user(s_user), .s_last(s_last), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_user(m_user), .m_last(m_last), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .image_count(image_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NPIX-1:0] data;
      logic [7:0]      user;
      logic            last;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cur_k = -1;
   int   first_stall = -1;
   int   edge_cnt = 0;
   bit   cke_toggle = 0;

   function automatic logic [7:0] pix(int mode, int k, int seed);
      case (mode)
         0:       return (k == 0) ? 8'hFF : ((k == NPIX-1) ? 8'h80 : 8'h00);
         1:       return (k % 2 == 1) ? 8'd128 : 8'd127;
         default: return 8'(((k * 73 + seed * 151) ^ ((k >> 3) * 29)) & 255);
      endcase
   endfunction

   function automatic exp_t build_exp(logic [7:0] label, int mode, int seed, int last_idx);
      exp_t e;
      e.user = label;
      e.last = (last_idx >= 0 && last_idx < NPIX);
      for (int k = 0; k < NPIX; k++) e.data[k] = (pix(mode, k, seed) > 8'd127);
      return e;
   endfunction

   task automatic send_image(input logic [7:0] label, input int mode, input int seed,
                             input int last_idx, input int npix, input bit push);
      int  waited;
      bit  acc;
      if (push) sb.push_back(build_exp(label, mode, seed, last_idx));
      first_stall = -1;
      edge_cnt = 0;
      for (int k = 0; k < npix; k++) begin
         cur_k   = k;
         s_valid = 1'b1;
         s_data  = pix(mode, k, seed);
         s_user  = (k == 0) ? label : ~label;
         s_last  = (k == last_idx);
         waited  = 0;
         acc     = 1'b0;
         while (!acc && waited < 2000) begin
            @(negedge clk);
            acc = s_ready;
            if (!acc && first_stall < 0) first_stall = k;
            @(posedge clk);
            #1;
            edge_cnt++;
            waited++;
         end
         if (!acc) begin
            checks++; failures++;
            $display("FAIL pixel_accept_timeout: pixel %0d not accepted, waited %0d cycles, required acceptance", k, waited);
            break;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      cur_k   = -1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_user = '0;
      cke = 1'b1; m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   always @(negedge clk) begin
      if (reset_n && cke && m_valid && m_ready) begin
         exp_t e;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: word with user=%0d emitted, scoreboard empty (required none)", m_user);
         end else begin
            e = sb.pop_front();
            if (m_data !== e.data) begin
               failures++;
               $display("FAIL sb_data: got %h required %h", m_data, e.data);
            end
            checks++;
            if (m_user !== e.user) begin
               failures++;
               $display("FAIL sb_user: got %0d required %0d", m_user, e.user);
            end
            checks++;
            if (m_last !== e.last) begin
               failures++;
               $display("FAIL sb_last: got %0b required %0b", m_last, e.last);
            end
         end
      end
   end

   task automatic test_reset();
      reset_n = 1'b0; cke = 1'b1; m_ready = 1'b0; s_valid = 1'b0;
      s_last = 1'b0; s_data = '0; s_user = '0;
      #3;
      checks++;
      if (m_valid !== 1'b0 || m_last !== 1'b0 || m_user !== 8'd0 || m_data !== '0 || image_count !== 32'd0) begin
         failures++;
         $display("FAIL reset_state: valid=%b last=%b user=%0d count=%0d required all zero", m_valid, m_last, m_user, image_count);
      end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         failures++; $display("FAIL ready_after_reset: got %b required 1", s_ready);
      end
      cke = 1'b0; #1;
      checks++;
      if (s_ready !== 1'b0) begin
         failures++; $display("FAIL ready_cke_low: got %b required 0", s_ready);
      end
      cke = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      send_image(8'd7, 0, 0, -1, NPIX, 1);
      checks++;
      if (m_valid !== 1'b1 || image_count !== 32'd1) begin
         failures++; $display("FAIL single_valid: valid=%b count=%0d required valid=1 count=1", m_valid, image_count);
      end
      checks++;
      if (m_data[0] !== 1'b1 || m_data[NPIX-1] !== 1'b1 || m_user !== 8'd7 || m_last !== 1'b0) begin
         failures++; $display("FAIL single_bits: b0=%b b783=%b user=%0d last=%b required 1 1 7 0", m_data[0], m_data[NPIX-1], m_user, m_last);
      end
      @(posedge clk); #1;
      checks++;
      if (m_valid !== 1'b0) begin
         failures++; $display("FAIL single_consumed: valid=%b required 0", m_valid);
      end
   endtask

   task automatic test_threshold();
      logic [NPIX-1:0] alt;
      alt = {392{2'b10}};
      do_reset();
      send_image(8'h55, 1, 0, -1, NPIX, 1);
      checks++;
      if (m_data !== alt) begin
         failures++; $display("FAIL threshold_edge: got %h required %h", m_data, alt);
      end
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      exp_t ea, eb;
      int   guard;
      ea = build_exp(8'd21, 2, 1, -1);
      eb = build_exp(8'd22, 2, 2, -1);
      do_reset();
      m_ready = 1'b0;
      send_image(8'd21, 2, 1, -1, NPIX, 1);
      checks++;
      if (first_stall !== -1) begin
         failures++; $display("FAIL bp_first_no_stall: stalled at %0d required -1", first_stall);
      end
      fork
         send_image(8'd22, 2, 2, -1, NPIX, 1);
      join_none
      #2;
      guard = 0;
      while (cur_k != NPIX-1 && guard < 2000) begin
         @(posedge clk); #2; guard++;
      end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || image_count !== 32'd1) begin
         failures++; $display("FAIL bp_stall: ready=%b valid=%b count=%0d required 0 1 1", s_ready, m_valid, image_count);
      end
      checks++;
      if (m_data !== ea.data || m_user !== ea.user) begin
         failures++; $display("FAIL bp_hold_stable: user=%0d data=%h required user=%0d", m_user, m_data, ea.user);
      end
      m_ready = 1'b1;
      @(posedge clk); #2;
      m_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || image_count !== 32'd2 || first_stall !== NPIX-1) begin
         failures++; $display("FAIL bp_swap: valid=%b count=%0d stall_at=%0d required 1 2 783", m_valid, image_count, first_stall);
      end
      checks++;
      if (m_data !== eb.data || m_user !== eb.user) begin
         failures++; $display("FAIL bp_second_word: user=%0d data=%h required user=%0d", m_user, m_data, eb.user);
      end
      m_ready = 1'b1;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_last();
      do_reset();
      send_image(8'd31, 2, 3, -1, NPIX, 1);
      send_image(8'd32, 2, 4, -1, NPIX, 1);
      send_image(8'd33, 2, 5, 500, NPIX, 1);
      checks++;
      if (m_last !== 1'b1 || image_count !== 32'd3) begin
         failures++; $display("FAIL last_flag: last=%b count=%0d required 1 3", m_last, image_count);
      end
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      m_ready = 1'b0;
      send_image(8'd40, 2, 6, -1, NPIX, 0);
      send_image(8'd41, 2, 8, -1, 400, 0);
      reset_n = 1'b0;
      #2;
      checks++;
      if (m_valid !== 1'b0 || image_count !== 32'd0) begin
         failures++; $display("FAIL reset_mid_drop: valid=%b count=%0d required 0 0", m_valid, image_count);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_ready = 1'b1;
      send_image(8'd3, 2, 9, -1, NPIX, 1);
      checks++;
      if (image_count !== 32'd1 || m_user !== 8'd3) begin
         failures++; $display("FAIL reset_mid_recover: count=%0d user=%0d required 1 3", image_count, m_user);
      end
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_cke();
      logic [NPIX-1:0] ref_word;
      do_reset();
      send_image(8'd50, 2, 7, -1, NPIX, 1);
      ref_word = m_data;
      checks++;
      if (edge_cnt !== NPIX) begin
         failures++; $display("FAIL cke_full_rate: %0d cycles required %0d", edge_cnt, NPIX);
      end
      repeat (2) @(posedge clk); #1;
      cke = 1'b1;
      cke_toggle = 1'b1;
      fork
         while (cke_toggle) begin
            @(posedge clk); #1;
            cke = ~cke;
         end
      join_none
      send_image(8'd50, 2, 7, -1, NPIX, 1);
      checks++;
      if (edge_cnt < 2*NPIX-1 || edge_cnt > 2*NPIX) begin
         failures++; $display("FAIL cke_half_rate: %0d cycles required %0d..%0d", edge_cnt, 2*NPIX-1, 2*NPIX);
      end
      checks++;
      if (m_valid !== 1'b1 || m_data !== ref_word) begin
         failures++; $display("FAIL cke_same_word: valid=%b data=%h", m_valid, m_data);
      end
      cke_toggle = 1'b0;
      repeat (3) @(posedge clk);
      #2 cke = 1'b1;
      repeat (3) @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_threshold();
      test_backpressure();
      test_last();
      test_reset_mid();
      test_cke();
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL sb_drained: %0d words outstanding required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
